// File: rtl/fa4_checker.sv
`default_nettype none
// ============================================================================
// Module   : fa4_checker
// Summary  : Drives operand vectors into an external 4-bit adder, waits SETTLE
//            cycles per vector, then checks the sum/carry and counts mismatches.
//            Define FA4_CHK_RANDOM_EN to use a 9-bit LFSR vector source instead
//            of the exhaustive up-counter.
// Revision : 1.0 - initial release
// ============================================================================
module fa4_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  output logic       dut_ci,
  input  logic [3:0] dut_s,
  input  logic       dut_co,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_cnt,
  output logic [9:0] vec_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] c_SETTLE = SETTLE[3:0];

`ifdef FA4_CHK_RANDOM_EN
  localparam logic [8:0] c_SEED = 9'h1FF;
  localparam logic [9:0] c_LAST = 10'd510;
`else
  localparam logic [8:0] c_SEED = 9'h000;
  localparam logic [9:0] c_LAST = 10'd511;
`endif

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [8:0] r_vec;
  logic [8:0] r_drv;
  logic [8:0] w_vec_nxt;
  logic [3:0] r_settle;
  logic [9:0] r_err;
  logic [9:0] r_vcnt;
  logic [4:0] w_expect;
  logic       w_mismatch;
  logic       w_last;
  logic       w_settled;

`ifdef FA4_CHK_RANDOM_EN
  assign w_vec_nxt = {r_vec[7:0], r_vec[8] ^ r_vec[4]};
`else
  assign w_vec_nxt = r_vec + 9'd1;
`endif

  // The vector count decides the end of run so both sources share one rule.
  assign w_last    = (r_vcnt == c_LAST);
  assign w_settled = (r_settle == 4'd1);
  assign w_expect  = {1'b0, r_drv[7:4]} + {1'b0, r_drv[3:0]} + {4'd0, r_drv[8]};
  // Case inequality so that X/Z on the adder result is scored as a mismatch.
  assign w_mismatch = ({dut_co, dut_s} !== w_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_WAIT;
      S_WAIT:         if (w_settled) w_next = S_CHECK;
      S_CHECK:        w_next = w_last ? S_DONE : S_WAIT;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec    <= c_SEED;
      r_drv    <= 9'd0;
      r_settle <= 4'd0;
      r_err    <= 10'd0;
      r_vcnt   <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_vec    <= c_SEED;
            r_drv    <= c_SEED;
            r_settle <= c_SETTLE;
            r_err    <= 10'd0;
            r_vcnt   <= 10'd0;
          end
        end
        S_WAIT: r_settle <= r_settle - 4'd1;
        S_CHECK: begin
          r_vcnt <= r_vcnt + 10'd1;
          if (w_mismatch) r_err <= r_err + 10'd1;
          if (!w_last) begin
            r_vec    <= w_vec_nxt;
            r_drv    <= w_vec_nxt;
            r_settle <= c_SETTLE;
          end
        end
        default: r_settle <= 4'd0;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_WAIT) || (r_state == S_CHECK);
    done = (r_state == S_DONE);
    pass = (r_state == S_DONE) && (r_err == 10'd0);
  end

  assign dut_ci  = r_drv[8];
  assign dut_a   = r_drv[7:4];
  assign dut_b   = r_drv[3:0];
  assign err_cnt = r_err;
  assign vec_cnt = r_vcnt;

endmodule
`default_nettype wire

// File: tb/tb_fa4_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fa4_checker
// Summary  : Emulates a 4-bit adder with selectable faults around fa4_checker
//            and compares every cycle against a run-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fa4_checker;

`ifdef FA4_CHK_RANDOM_EN
  localparam int         S     = 1;
  localparam int         N     = 511;
  localparam logic [8:0] FIRST = 9'h1FF;
`else
  localparam int         S     = 2;
  localparam int         N     = 512;
  localparam logic [8:0] FIRST = 9'h000;
`endif
  localparam int RUN_CYC = N * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_ci;
  logic [3:0] dut_s;
  logic       dut_co;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_cnt;
  logic [9:0] vec_cnt;

  fa4_checker #(.SETTLE(S)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dut_a   (dut_a),
    .dut_b   (dut_b),
    .dut_ci  (dut_ci),
    .dut_s   (dut_s),
    .dut_co  (dut_co),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .vec_cnt (vec_cnt)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  logic [8:0] seq_tbl [N];
  bit         bad_tbl [512];
  logic [4:0] flip_tbl [512];
  int         bad_pre [N+1];
  int         m_n = 0;
  bit         m_done = 1'b0;
  logic [4:0] w_resp;

  // Adder under test: correct sum, corrupted by flip_tbl on vectors marked bad.
  always_comb begin
    w_resp = {1'b0, dut_a} + {1'b0, dut_b} + {4'd0, dut_ci};
    if (bad_tbl[{dut_ci, dut_a, dut_b}]) w_resp = w_resp ^ flip_tbl[{dut_ci, dut_a, dut_b}];
    dut_co = w_resp[4];
    dut_s  = w_resp[3:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0 correct, 1 carry-out stuck at 0, 2 sum inverted, 3 random faults
  task automatic setup(input int mode);
    logic [4:0] sum;
    for (int v = 0; v < 512; v++) begin
      sum = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      case (mode)
        1:       begin bad_tbl[v] = sum[4]; flip_tbl[v] = 5'h10; end
        2:       begin bad_tbl[v] = 1'b1;   flip_tbl[v] = 5'h0F; end
        3:       begin bad_tbl[v] = ($urandom_range(0, 3) == 0); flip_tbl[v] = 5'($urandom_range(1, 31)); end
        default: begin bad_tbl[v] = 1'b0;   flip_tbl[v] = 5'h00; end
      endcase
    end
    bad_pre[0] = 0;
    for (int k = 0; k < N; k++) bad_pre[k+1] = bad_pre[k] + int'(bad_tbl[seq_tbl[k]]);
  endtask

  // m_n = clock edges since (and including) the edge that accepted start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n    <= 0;
      m_done <= 1'b0;
    end else if (start && (m_n == 0 || m_done)) begin
      m_n    <= 1;
      m_done <= 1'b0;
    end else if (m_n > 0 && !m_done) begin
      m_n    <= m_n + 1;
      m_done <= (m_n + 1 == RUN_CYC);
    end
  end

  always @(negedge clk) begin : p_cmp
    int k;
    if (chk_en) begin
      if (m_n == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_pass", pass, 0);
        chk("idle_err", err_cnt, 0);
        chk("idle_vec", vec_cnt, 0);
        chk("idle_drive", {dut_ci, dut_a, dut_b}, 0);
      end else begin
        k = (m_n - 1) / (S + 1);
        chk("vec_cnt", vec_cnt, k);
        chk("err_cnt", err_cnt, bad_pre[k]);
        chk("busy", busy, !m_done);
        chk("done", done, m_done);
        chk("pass", pass, m_done && bad_pre[k] == 0);
        if (!m_done) chk("drive", {dut_ci, dut_a, dut_b}, seq_tbl[k]);
      end
    end
  end

  task automatic run(input int mode, input int repulse_at, input int abort_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    setup(mode);
    chk("first_vec", {dut_ci, dut_a, dut_b}, FIRST);
    chk("start_busy", busy, 1);
    while (done !== 1'b1 && cyc < RUN_CYC + 50) begin
      if (cyc == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_vec", vec_cnt, 0);
        chk("rst_drive", {dut_ci, dut_a, dut_b}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start = (cyc == repulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_reached", done, 1);
  endtask

  initial begin
    int cyc;
    logic [8:0] v;
    rst   = 1'b1;
    start = 1'b0;
    v = 9'h1FF;
    for (int k = 0; k < N; k++) begin
`ifdef FA4_CHK_RANDOM_EN
      seq_tbl[k] = v;
      v = {v[7:0], v[8] ^ v[4]};
`else
      seq_tbl[k] = 9'(k);
`endif
    end
    setup(0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    run(0, -1, -1, cyc);
    chk("latency_correct", cyc, RUN_CYC);
    chk("pass_correct", pass, 1);
    chk("vec_final", vec_cnt, N);
    repeat (5) @(negedge clk);

    run(1, -1, -1, cyc);
    chk("err_stuck_co", err_cnt, 256);
    chk("pass_stuck_co", pass, 0);

    run(2, -1, -1, cyc);
    chk("err_inverted", err_cnt, N);
    chk("pass_inverted", pass, 0);

    run(0, 100, -1, cyc);
    chk("latency_repulse", cyc, RUN_CYC);
    chk("vec_repulse", vec_cnt, N);

    for (int r = 0; r < 2; r++) begin
      run(3, int'($urandom_range(10, RUN_CYC - 10)), -1, cyc);
      chk("latency_rand", cyc, RUN_CYC);
      chk("err_rand", err_cnt, bad_pre[N]);
    end

    run(0, -1, 700, cyc);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done, 0);
    run(0, -1, -1, cyc);
    chk("latency_after_rst", cyc, RUN_CYC);
    chk("pass_after_rst", pass, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
